// File: rtl/vco_adc_pkg.sv
// Shared types and constants for the ring-VCO ADC controller.
package vco_adc_pkg;

  localparam int RING_STATES = 64;  // distinct phases of the 32-stage ring
  localparam int PH_W        = 6;   // bits needed for a phase 0..63
  localparam int SAMP_W      = 32;  // sampler width, one bit per ring stage
  localparam int NIB_N       = SAMP_W / 4;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    PRIME,
    CONV,
    DONE
  } state_t;

  // Forward phase advance between two snapshots; modulo-64 wrap is implicit.
  function automatic logic [PH_W-1:0] phase_delta(input logic [PH_W-1:0] p_now,
                                                  input logic [PH_W-1:0] p_old);
    return p_now - p_old;
  endfunction

endpackage

// File: rtl/vco_adc_ctrl_if.sv
// Control/result bus between a host and the VCO ADC controller.
interface vco_adc_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int WIN_W = 16,
  parameter int SET_W = 8
) ();

  logic             start;
  logic             abort;
  logic [SET_W-1:0] cfg_settle;
  logic [WIN_W-1:0] cfg_win;
  logic             busy;
  logic [ACC_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             ovf;

  // Host side: issues commands and consumes results.
  modport master (
    output start, abort, cfg_settle, cfg_win, result_ready,
    input  busy, result, result_valid, ovf
  );

  // Controller side.
  modport slave (
    input  start, abort, cfg_settle, cfg_win, result_ready,
    output busy, result, result_valid, ovf
  );

endinterface

// File: rtl/vco_phase_dec.sv
// Bubble-tolerant decode of a 32-bit ring snapshot into a 6-bit phase.
// Counting ones (rather than locating the edge) absorbs sampler bubbles;
// bit 0 tells which half-turn of the ring we are in.
module vco_phase_dec
  import vco_adc_pkg::*;
(
  input  logic [SAMP_W-1:0] samp_word,
  output logic [PH_W-1:0]   phase
);

  logic [2:0]      nib_cnt [NIB_N];
  logic [PH_W-1:0] ones;

  genvar gi;
  generate
    for (gi = 0; gi < NIB_N; gi++) begin : g_nib
      assign nib_cnt[gi] = 3'(samp_word[4*gi])   + 3'(samp_word[4*gi+1]) +
                           3'(samp_word[4*gi+2]) + 3'(samp_word[4*gi+3]);
    end
  endgenerate

  // Sum nibble counts, then fold the falling half-turn onto 33..63.
  always_comb begin
    ones = '0;
    for (int i = 0; i < NIB_N; i++) begin
      ones = ones + PH_W'(nib_cnt[i]);
    end
    if (samp_word[0]) begin
      phase = ones;
    end else begin
      phase = PH_W'(RING_STATES) - ones;
    end
  end

endmodule

// File: rtl/vco_adc_ctrl.sv
// Sequencer for the ring VCO: enable, settle, then accumulate phase
// advance over a window and hand the count out via valid/ready.
module vco_adc_ctrl
  import vco_adc_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int WIN_W = 16,
  parameter int SET_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SAMP_W-1:0] samp,
  output logic              sw_vco,
  vco_adc_ctrl_if.slave     bus
);

  state_t           state_reg,      state_next;
  logic [SAMP_W-1:0] samp_q_reg;
  logic [PH_W-1:0]  p_prev_reg,     p_prev_next;
  logic [ACC_W-1:0] acc_reg,        acc_next;
  logic [ACC_W-1:0] result_reg,     result_next;
  logic             ovf_reg,        ovf_next;
  logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [WIN_W-1:0] win_cnt_reg,    win_cnt_next;
  logic             sw_vco_reg;
  logic             busy_reg;
  logic             valid_reg;

  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  delta;
  logic [ACC_W:0]   acc_sum;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_sat;

  vco_phase_dec u_dec (
    .samp_word (samp_q_reg),
    .phase     (phase)
  );

  assign delta   = phase_delta(phase, p_prev_reg);
  assign acc_sum = {1'b0, acc_reg} + (ACC_W+1)'(delta);
  assign sat_hit = acc_sum[ACC_W];
  assign acc_sat = sat_hit ? '1 : acc_sum[ACC_W-1:0];

  // Snapshot the sampler every cycle so the decoder sees a registered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q_reg <= '0;
    end else begin
      samp_q_reg <= samp;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      p_prev_reg     <= '0;
      acc_reg        <= '0;
      result_reg     <= '0;
      ovf_reg        <= 1'b0;
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      p_prev_reg     <= p_prev_next;
      acc_reg        <= acc_next;
      result_reg     <= result_next;
      ovf_reg        <= ovf_next;
      settle_cnt_reg <= settle_cnt_next;
      win_cnt_reg    <= win_cnt_next;
    end
  end

  // Next-state and datapath update; abort wins over everything else.
  always_comb begin
    state_next      = state_reg;
    p_prev_next     = p_prev_reg;
    acc_next        = acc_reg;
    result_next     = result_reg;
    ovf_next        = ovf_reg;
    settle_cnt_next = settle_cnt_reg;
    win_cnt_next    = win_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort && (bus.cfg_win != '0)) begin
          state_next      = SETTLE;
          settle_cnt_next = (bus.cfg_settle == '0) ? SET_W'(1) : bus.cfg_settle;
          win_cnt_next    = bus.cfg_win;
          acc_next        = '0;
          ovf_next        = 1'b0;
        end
      end
      SETTLE: begin
        if (settle_cnt_reg <= SET_W'(1)) begin
          state_next = PRIME;
        end else begin
          settle_cnt_next = settle_cnt_reg - SET_W'(1);
        end
      end
      PRIME: begin
        p_prev_next = phase;
        state_next  = CONV;
      end
      CONV: begin
        acc_next    = acc_sat;
        ovf_next    = ovf_reg | sat_hit;
        p_prev_next = phase;
        if (win_cnt_reg == WIN_W'(1)) begin
          state_next  = DONE;
          result_next = acc_sat;
        end else begin
          win_cnt_next = win_cnt_reg - WIN_W'(1);
        end
      end
      DONE: begin
        if (valid_reg && bus.result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (bus.abort && (state_reg != IDLE)) begin
      state_next  = IDLE;
      ovf_next    = 1'b0;
      result_next = result_reg;
    end
  end

  // Status outputs are flops decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_vco_reg <= 1'b0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      sw_vco_reg <= (state_next == SETTLE) || (state_next == PRIME) ||
                    (state_next == CONV);
      busy_reg   <= (state_next != IDLE);
      valid_reg  <= (state_next == DONE);
    end
  end

  assign sw_vco           = sw_vco_reg;
  assign bus.busy         = busy_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.ovf          = ovf_reg;

endmodule

// File: tb/tb_vco_adc_ctrl.sv
// Scoreboard bench for vco_adc_ctrl: expected counts are computed from the
// driven sample stream and compared when the result handshake happens.
module tb_vco_adc_ctrl;

  localparam int TB_ACC_W = 8;
  localparam int ACC_MAX  = (1 << TB_ACC_W) - 1;

  typedef struct {
    int res;
    int ov;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] samp;
  logic        sw_vco;

  int   checks;
  int   errors;
  int   last_result;
  exp_t sb_q[$];

  vco_adc_ctrl_if #(.ACC_W(TB_ACC_W), .WIN_W(16), .SET_W(8)) bus_if ();

  vco_adc_ctrl #(.ACC_W(TB_ACC_W), .WIN_W(16), .SET_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .samp   (samp),
    .sw_vco (sw_vco),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Thermometer word whose decoded phase is ph mod 64.
  function automatic logic [31:0] enc_phase(input int ph);
    logic [31:0] w;
    int p;
    p = ph % 64;
    if (p == 0) begin
      w = '0;
    end else if (p <= 32) begin
      w = '0;
      for (int i = 0; i < p; i++) w[i] = 1'b1;
    end else begin
      w = '1;
      for (int i = 0; i < p - 32; i++) w[i] = 1'b0;
    end
    return w;
  endfunction

  function automatic int dec_phase(input logic [31:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < 32; i++) ones += int'(w[i]);
    if (w[0]) return ones;
    return (64 - ones) % 64;
  endfunction

  // mode 0: ramp base+step*j; mode 1: zeros / ones / bubbled ones.
  function automatic logic [31:0] gen_samp(input int mode, input int base, input int step, input int j);
    logic [31:0] pat [3];
    pat[0] = 32'h0000_0000;
    pat[1] = 32'hFFFF_FFFF;
    pat[2] = 32'hFFFF_FFF7;
    if (mode == 1) return pat[j % 3];
    return enc_phase(base + step * j);
  endfunction

  task automatic run_conv(input int s, input int w, input int mode, input int base,
                          input int step, input int hold, input int abort_at);
    int se, pprev, pnow, acc, ov, k, h;
    bit aborted;
    exp_t e;
    logic [TB_ACC_W-1:0] held;
    se = (s == 0) ? 1 : s;
    pprev = dec_phase(gen_samp(mode, base, step, se));
    acc = 0;
    ov = 0;
    for (int j = se + 1; j <= se + w; j++) begin
      pnow = dec_phase(gen_samp(mode, base, step, j));
      acc += (pnow - pprev + 64) % 64;
      if (acc > ACC_MAX) begin
        acc = ACC_MAX;
        ov = 1;
      end
      pprev = pnow;
    end
    e.res = acc;
    e.ov = ov;
    if (abort_at < 0) sb_q.push_back(e);

    bus_if.cfg_settle   = 8'(s);
    bus_if.cfg_win      = 16'(w);
    bus_if.start        = 1'b1;
    bus_if.result_ready = 1'b0;
    samp = gen_samp(mode, base, step, 0);
    @(posedge clk); #1;
    bus_if.start      = 1'b0;
    bus_if.cfg_settle = 8'($urandom_range(0, 255));
    bus_if.cfg_win    = 16'($urandom_range(1, 3));

    aborted = 1'b0;
    for (k = 0; k < se + w + 1; k++) begin
      check("busy_run", 32'(bus_if.busy), 1);
      check("sw_vco_run", 32'(sw_vco), 1);
      check("valid_run", 32'(bus_if.result_valid), 0);
      if (k == abort_at) bus_if.abort = 1'b1;
      samp = gen_samp(mode, base, step, k + 1);
      @(posedge clk); #1;
      if (bus_if.abort) begin
        bus_if.abort = 1'b0;
        aborted = 1'b1;
        break;
      end
    end

    if (aborted) begin
      check("abort_busy", 32'(bus_if.busy), 0);
      check("abort_sw_vco", 32'(sw_vco), 0);
      check("abort_ovf", 32'(bus_if.ovf), 0);
      check("abort_result", 32'(bus_if.result), 32'(last_result));
      bus_if.result_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        check("abort_valid", 32'(bus_if.result_valid), 0);
        @(posedge clk); #1;
      end
      $display("TXN abort s=%0d w=%0d at=%0d result=%0d", s, w, abort_at, bus_if.result);
      return;
    end

    for (h = 0; h <= hold; h++) begin
      check("valid_done", 32'(bus_if.result_valid), 1);
      check("sw_vco_done", 32'(sw_vco), 0);
      check("busy_done", 32'(bus_if.busy), 1);
      if (h == 0) held = bus_if.result;
      else check("result_held", 32'(bus_if.result), 32'(held));
      bus_if.result_ready = (h >= hold);
      if (bus_if.result_ready) begin
        bus_if.start = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          e = sb_q.pop_front();
          check("result", 32'(bus_if.result), 32'(e.res));
          check("ovf", 32'(bus_if.ovf), 32'(e.ov));
          last_result = e.res;
          $display("TXN conv s=%0d w=%0d hold=%0d result=%0d ovf=%0d exp=%0d/%0d",
                   s, w, hold, bus_if.result, bus_if.ovf, e.res, e.ov);
        end
        @(posedge clk); #1;
        break;
      end
      bus_if.start   = 1'b1;
      bus_if.cfg_win = 16'd3;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
    end
    check("busy_after", 32'(bus_if.busy), 0);
    check("valid_after", 32'(bus_if.result_valid), 0);
    @(posedge clk); #1;
    check("busy_idle", 32'(bus_if.busy), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_result = 0;
    rst_n = 1'b0;
    samp = '0;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.cfg_settle = '0;
    bus_if.cfg_win = '0;
    bus_if.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_if.busy), 0);
    check("rst_sw_vco", 32'(sw_vco), 0);
    check("rst_valid", 32'(bus_if.result_valid), 0);
    check("rst_ovf", 32'(bus_if.ovf), 0);
    check("rst_result", 32'(bus_if.result), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_conv(4, 10, 0, 0, 3, 0, -1);   // basic +3 per cycle
    run_conv(2, 8, 0, 54, 3, 0, -1);   // wrap 60,63,2,...
    run_conv(0, 6, 1, 0, 0, 0, -1);    // zeros/ones/bubble, settle 0 -> 1
    run_conv(3, 5, 0, 10, 63, 0, -1);  // deltas of 63 saturate 8-bit acc
    run_conv(2, 4, 0, 7, 5, 5, -1);    // backpressure with start pulses
    run_conv(3, 8, 0, 0, 2, 0, 6);     // abort in CONV cycle 3

    // abort together with start in IDLE
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    bus_if.cfg_win = 16'd4;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    check("abort_start_busy", 32'(bus_if.busy), 0);

    // start with zero window is ignored
    bus_if.start = 1'b1;
    bus_if.cfg_win = 16'd0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check("win0_busy", 32'(bus_if.busy), 0);
    @(posedge clk); #1;
    check("win0_sw_vco", 32'(sw_vco), 0);

    // reset during SETTLE clears outputs without waiting for a clock
    bus_if.cfg_settle = 8'd6;
    bus_if.cfg_win = 16'd5;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(bus_if.busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus_if.busy), 0);
    check("arst_sw_vco", 32'(sw_vco), 0);
    check("arst_valid", 32'(bus_if.result_valid), 0);
    check("arst_ovf", 32'(bus_if.ovf), 0);
    check("arst_result", 32'(bus_if.result), 0);
    last_result = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(bus_if.busy), 0);

    run_conv(1, 3, 0, 20, 7, 0, -1);   // recovery after reset

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
